// File: rtl/hydration_pkg.sv
// Shared types and helpers for the hydration reminder.
package hydration_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALERT    = 2'd1,
    SNOOZE   = 2'd2,
    ESCALATE = 2'd3
  } state_t;

  localparam int MAX_HOUR = 23;

  // Converts the RTC's BCD hour digits to binary; returns {valid, hour[4:0]}.
  // Any hour that is not a legal 00..23 clears the valid bit.
  function automatic logic [5:0] bcd_hour_to_bin(input logic [3:0] msd,
                                                 input logic [3:0] lsd);
    logic [7:0] bin;
    logic       valid;
    bin   = 8'(msd) * 8'd10 + 8'(lsd);
    valid = (msd <= 4'd2) && (lsd <= 4'd9) && (bin <= 8'(MAX_HOUR));
    return {valid, bin[4:0]};
  endfunction

endpackage

// File: rtl/hydration_sched_cmp.sv
// Decides whether the remaining water is behind the daily drinking schedule.
module hydration_sched_cmp
  import hydration_pkg::*;
#(
  parameter int LEVEL_W         = 4,
  parameter int END_HOUR        = 23,
  parameter int HOURS_PER_LEVEL = 1
) (
  input  logic [LEVEL_W-1:0] water_level,
  input  logic [3:0]         hMSD,
  input  logic [3:0]         hLSD,
  output logic               due
);

  // Wide enough that hour + level*HOURS_PER_LEVEL never wraps.
  localparam int SUM_W = (LEVEL_W + 8 > 10) ? LEVEL_W + 8 : 10;

  logic [5:0]       dec;
  logic [SUM_W-1:0] sum;

  // Due when the hours still needed for the remaining levels reach past END_HOUR.
  always_comb begin
    dec = bcd_hour_to_bin(hMSD, hLSD);
    sum = SUM_W'(dec[4:0]) + SUM_W'(water_level) * SUM_W'(HOURS_PER_LEVEL);
    due = dec[5] && (water_level != '0) && (sum >= SUM_W'(END_HOUR));
  end

endmodule

// File: rtl/hydration_reminder_fsm.sv
// Alert / snooze / escalate reminder driven by the drinking schedule.
module hydration_reminder_fsm
  import hydration_pkg::*;
#(
  parameter int LEVEL_W         = 4,
  parameter int END_HOUR        = 23,
  parameter int HOURS_PER_LEVEL = 1,
  parameter int SNOOZE_MIN      = 10,
  parameter int ESC_MIN         = 5,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_min,
  input  logic [LEVEL_W-1:0] water_level,
  input  logic [3:0]         hMSD,
  input  logic [3:0]         hLSD,
  input  logic               ack,
  output logic               remind,
  output logic               urgent,
  output logic               snoozed,
  output logic [CNT_W-1:0]   alert_count
);

  state_t             state, state_nx;
  logic [7:0]         esc_tmr, esc_nx;
  logic [7:0]         snz_tmr, snz_nx;
  logic               cnt_inc;
  logic [LEVEL_W-1:0] prev_level;
  logic               due;
  logic               drank;

  hydration_sched_cmp #(
    .LEVEL_W        (LEVEL_W),
    .END_HOUR       (END_HOUR),
    .HOURS_PER_LEVEL(HOURS_PER_LEVEL)
  ) u_sched (
    .water_level(water_level),
    .hMSD       (hMSD),
    .hLSD       (hLSD),
    .due        (due)
  );

  // A drop in level since the previous clock means the user drank; a refill does not count.
  assign drank = water_level < prev_level;

  // Next state and timer updates; priority is drank/!due, then ack, then tick_min.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise paths that
    // do not assign it would infer a latch.
    state_nx = state;
    esc_nx   = esc_tmr;
    snz_nx   = snz_tmr;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (due && !drank) begin
          state_nx = ALERT;
          esc_nx   = 8'(ESC_MIN);
          cnt_inc  = 1'b1;
        end
      end
      ALERT: begin
        if (drank || !due) begin
          state_nx = IDLE;
        end else if (ack) begin
          state_nx = SNOOZE;
          snz_nx   = 8'(SNOOZE_MIN);
        end else if (tick_min) begin
          esc_nx = esc_tmr - 8'd1;
          if (esc_tmr == 8'd1) state_nx = ESCALATE;
        end
      end
      ESCALATE: begin
        if (drank || !due) begin
          state_nx = IDLE;
        end else if (ack) begin
          state_nx = SNOOZE;
          snz_nx   = 8'(SNOOZE_MIN);
        end
      end
      SNOOZE: begin
        // ack is deliberately ignored here so a repeated press cannot extend the snooze.
        if (drank || !due) begin
          state_nx = IDLE;
        end else if (tick_min) begin
          snz_nx = snz_tmr - 8'd1;
          if (snz_tmr == 8'd1) begin
            state_nx = ALERT;
            esc_nx   = 8'(ESC_MIN);
            cnt_inc  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, timers, level history, saturating counter and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      esc_tmr     <= '0;
      snz_tmr     <= '0;
      prev_level  <= '0;
      alert_count <= '0;
      remind      <= 1'b0;
      urgent      <= 1'b0;
      snoozed     <= 1'b0;
    end else begin
      state      <= state_nx;
      esc_tmr    <= esc_nx;
      snz_tmr    <= snz_nx;
      prev_level <= water_level;
      if (cnt_inc && (alert_count != '1)) alert_count <= alert_count + CNT_W'(1);
      remind  <= (state_nx == ALERT) || (state_nx == ESCALATE);
      urgent  <= (state_nx == ESCALATE);
      snoozed <= (state_nx == SNOOZE);
    end
  end

endmodule

// File: tb/tb_hydration_reminder_fsm.sv
// Scoreboard bench: three configurations driven in lockstep against a reference model.
module tb_hydration_reminder_fsm;

  localparam int ESC = 5;
  localparam int SNZ = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_min = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] water_level = '0;
  logic [5:0] water_level_p = '0;
  logic [3:0] hMSD = '0;
  logic [3:0] hLSD = '0;

  logic       remind_a, urgent_a, snoozed_a;
  logic [7:0] count_a;
  logic       remind_c, urgent_c, snoozed_c;
  logic [1:0] count_c;
  logic       remind_p, urgent_p, snoozed_p;
  logic [7:0] count_p;

  always #5 clk = ~clk;

  hydration_reminder_fsm #(
    .LEVEL_W(4), .END_HOUR(23), .HOURS_PER_LEVEL(1),
    .SNOOZE_MIN(SNZ), .ESC_MIN(ESC), .CNT_W(8)
  ) dut_a (
    .clk(clk), .reset(reset), .tick_min(tick_min), .water_level(water_level),
    .hMSD(hMSD), .hLSD(hLSD), .ack(ack),
    .remind(remind_a), .urgent(urgent_a), .snoozed(snoozed_a), .alert_count(count_a)
  );

  hydration_reminder_fsm #(
    .LEVEL_W(4), .END_HOUR(23), .HOURS_PER_LEVEL(1),
    .SNOOZE_MIN(SNZ), .ESC_MIN(ESC), .CNT_W(2)
  ) dut_c (
    .clk(clk), .reset(reset), .tick_min(tick_min), .water_level(water_level),
    .hMSD(hMSD), .hLSD(hLSD), .ack(ack),
    .remind(remind_c), .urgent(urgent_c), .snoozed(snoozed_c), .alert_count(count_c)
  );

  hydration_reminder_fsm #(
    .LEVEL_W(6), .END_HOUR(21), .HOURS_PER_LEVEL(2),
    .SNOOZE_MIN(SNZ), .ESC_MIN(ESC), .CNT_W(8)
  ) dut_p (
    .clk(clk), .reset(reset), .tick_min(tick_min), .water_level(water_level_p),
    .hMSD(hMSD), .hLSD(hLSD), .ack(ack),
    .remind(remind_p), .urgent(urgent_p), .snoozed(snoozed_p), .alert_count(count_p)
  );

  // Reference model: an alert phase that remembers whether it escalated, a snooze
  // phase, and a minute counter for whichever phase is running.
  typedef struct {
    bit alerting;
    bit escalated;
    bit snoozing;
    int mins;
    int count;
    int prev;
  } mdl_t;

  typedef struct {
    int a;
    int c;
    int p;
  } exp_t;

  mdl_t ma, mc, mp;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   p_level = -1;
  int   cur_lvl, cur_msd, cur_lsd;

  function automatic int pack_out(logic r, logic u, logic s, int c);
    return (int'(r) << 10) | (int'(u) << 9) | (int'(s) << 8) | c;
  endfunction

  function automatic mdl_t model_next(mdl_t m, int lvl, int msd, int lsd, bit a, bit t,
                                      int end_hour, int hpl, int cnt_max);
    int hour;
    bit valid, due, drank;
    hour  = msd * 10 + lsd;
    valid = (msd <= 2) && (lsd <= 9) && (hour <= 23);
    due   = valid && (lvl != 0) && (hour + lvl * hpl >= end_hour);
    drank = lvl < m.prev;
    if (!m.alerting && !m.snoozing) begin
      if (due && !drank) begin
        m.alerting = 1; m.escalated = 0; m.mins = 0;
        if (m.count < cnt_max) m.count++;
      end
    end else if (drank || !due) begin
      m.alerting = 0; m.escalated = 0; m.snoozing = 0;
    end else if (m.alerting) begin
      if (a) begin
        m.alerting = 0; m.escalated = 0; m.snoozing = 1; m.mins = 0;
      end else if (t && !m.escalated) begin
        m.mins++;
        if (m.mins == ESC) m.escalated = 1;
      end
    end else if (t) begin
      m.mins++;
      if (m.mins == SNZ) begin
        m.snoozing = 0; m.alerting = 1; m.escalated = 0; m.mins = 0;
        if (m.count < cnt_max) m.count++;
      end
    end
    m.prev = lvl;
    return m;
  endfunction

  function automatic int model_out(mdl_t m);
    return pack_out(m.alerting, m.alerting && m.escalated, m.snoozing, m.count);
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s at %0t: got r/u/s/cnt=%0b/%0b/%0b/%0d expected %0b/%0b/%0b/%0d",
                  name, $time, got[10], got[9], got[8], got[7:0],
                  exp[10], exp[9], exp[8], exp[7:0]);
  endtask

  // Called at a falling edge: apply one cycle of inputs, queue the expected response.
  task automatic step(int lvl, int msd, int lsd, bit a, bit t);
    int   lp;
    exp_t e;
    lp = (p_level >= 0) ? p_level : lvl;
    water_level   = 4'(lvl);
    water_level_p = 6'(lp);
    hMSD          = 4'(msd);
    hLSD          = 4'(lsd);
    ack           = a;
    tick_min      = t;
    ma = model_next(ma, lvl, msd, lsd, a, t, 23, 1, 255);
    mc = model_next(mc, lvl, msd, lsd, a, t, 23, 1, 3);
    mp = model_next(mp, lp, msd, lsd, a, t, 21, 2, 255);
    e.a = model_out(ma);
    e.c = model_out(mc);
    e.p = model_out(mp);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset between clock edges, checks outputs clear immediately, releases.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("async_reset_a", pack_out(remind_a, urgent_a, snoozed_a, int'(count_a)), 0);
    check("async_reset_c", pack_out(remind_c, urgent_c, snoozed_c, int'(count_c)), 0);
    check("async_reset_p", pack_out(remind_p, urgent_p, snoozed_p, int'(count_p)), 0);
    @(negedge clk);
    reset = 1'b0;
    ma = '{default: 0};
    mc = '{default: 0};
    mp = '{default: 0};
  endtask

  // Monitor: outputs settle after each rising edge; compare against the queued response.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("dut_a", pack_out(remind_a, urgent_a, snoozed_a, int'(count_a)), mon_e.a);
      check("dut_c", pack_out(remind_c, urgent_c, snoozed_c, int'(count_c)), mon_e.c);
      check("dut_p", pack_out(remind_p, urgent_p, snoozed_p, int'(count_p)), mon_e.p);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ma = '{default: 0};
    mc = '{default: 0};
    mp = '{default: 0};
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset with nothing due.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Legacy schedule sweep over every level and hour.
    for (int lvl = 0; lvl < 16; lvl++)
      for (int h = 0; h < 24; h++) begin
        step(lvl, h / 10, h % 10, 0, 0);
        step(lvl, h / 10, h % 10, 0, 0);
      end

    // Escalation, acknowledge, snooze expiry.
    do_reset();
    step(15, 1, 2, 0, 0);
    repeat (4) begin step(15, 1, 2, 0, 1); step(15, 1, 2, 0, 0); end
    step(15, 1, 2, 0, 1);
    repeat (2) step(15, 1, 2, 0, 1);
    step(15, 1, 2, 1, 0);
    repeat (10) begin step(15, 1, 2, 0, 1); step(15, 1, 2, 0, 0); end

    // Escalate again, then a drink clears it and the still-due schedule re-alerts.
    repeat (5) step(15, 1, 2, 0, 1);
    step(15, 1, 2, 0, 0);
    step(14, 1, 2, 0, 0);
    step(14, 1, 2, 0, 0);

    // ack and the final escalation tick together: snooze wins.
    repeat (4) step(14, 1, 2, 0, 1);
    step(14, 1, 2, 1, 1);
    step(14, 1, 2, 1, 0);
    repeat (10) step(14, 1, 2, 1'($urandom_range(0, 1)), 1);
    step(14, 1, 2, 0, 0);

    // Invalid hours never raise an alert.
    do_reset();
    repeat (3) step(15, 2, 5, 0, 0);
    step(15, 2, 4, 0, 0);
    step(15, 1, 10, 0, 0);
    step(15, 3, 0, 0, 0);

    // Five alert entries saturate the 2-bit counter.
    repeat (5) begin step(15, 1, 2, 0, 0); step(0, 1, 2, 0, 0); end
    repeat (2) step(15, 1, 2, 0, 0);

    // Wider-level configuration: level 3 due at 15:00, not at 14:00.
    do_reset();
    p_level = 3;
    repeat (2) step(0, 1, 4, 0, 0);
    repeat (2) step(0, 1, 5, 0, 0);
    repeat (2) step(0, 1, 4, 0, 0);
    p_level = -1;

    // Reach ALERT with alert_count=3, then reset mid-operation.
    do_reset();
    repeat (2) begin step(15, 1, 2, 0, 0); step(15, 1, 2, 0, 0); step(15, 0, 0, 0, 0); end
    step(15, 1, 2, 0, 0);
    step(15, 1, 2, 0, 0);
    do_reset();
    repeat (3) step(15, 0, 0, 0, 0);

    // Randomized traffic.
    cur_lvl = 15; cur_msd = 1; cur_lsd = 2;
    repeat (1500) begin
      if ($urandom_range(0, 99) < 8) cur_lvl = int'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5) begin
        cur_msd = int'($urandom_range(0, 3));
        cur_lsd = int'($urandom_range(0, 11));
      end
      step(cur_lvl, cur_msd, cur_lsd,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 25);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
